// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single ram_rw port between IF and LS, LS-first with bounded IF starvation and a WAIT timeout
module mem_arbiter #(
   parameter int MAX_LS_STREAK = 4,
   parameter int TIMEOUT       = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid_i,
   input  logic [63:0] if_addr_i,
   output logic        if_ready_o,
   output logic [63:0] if_rdata_o,
   output logic        if_err_o,
   input  logic        ls_valid_i,
   input  logic        ls_wen_i,
   input  logic [63:0] ls_addr_i,
   input  logic [63:0] ls_wdata_i,
   input  logic [7:0]  ls_wmask_i,
   input  logic [2:0]  ls_size_i,
   output logic        ls_ready_o,
   output logic [63:0] ls_rdata_o,
   output logic        ls_err_o,
   output logic        ram_rw_cen_o,
   output logic        ram_rw_wen_o,
   output logic [63:0] ram_rw_addr_o,
   output logic [63:0] ram_rw_wdata_o,
   output logic [7:0]  ram_rw_wmask_o,
   output logic [2:0]  ram_rw_size_o,
   input  logic        ram_rw_ready_i,
   input  logic [63:0] ram_rw_data_i
);
   localparam int SW = $clog2(MAX_LS_STREAK + 1);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] SMAX = SW'(MAX_LS_STREAK);
   localparam logic [WW-1:0] TLAST = WW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_nxt;
   logic gnt_ls, take_ls, take_if, timeout;
   logic [SW-1:0] streak_cnt;
   logic [WW-1:0] wait_cnt;
   logic [63:0] rdata_q;
   logic err_q;
   always_comb begin
      take_ls = ls_valid_i && (!if_valid_i || streak_cnt != SMAX);
      take_if = if_valid_i && !take_ls;
      timeout = wait_cnt == TLAST;
      state_nxt = state;
      unique case (state)
         IDLE:  state_nxt = (take_ls || take_if) ? ISSUE : IDLE;
         ISSUE: state_nxt = WAIT;
         WAIT:  state_nxt = (ram_rw_ready_i || timeout) ? RESP : WAIT;
         RESP:  state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      state <= !rst_n ? IDLE : state_nxt;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_ls         <= 1'b0;
         ram_rw_wen_o   <= 1'b0;
         ram_rw_addr_o  <= '0;
         ram_rw_wdata_o <= '0;
         ram_rw_wmask_o <= '0;
         ram_rw_size_o  <= '0;
         streak_cnt     <= '0;
         wait_cnt       <= '0;
         rdata_q        <= '0;
         err_q          <= 1'b0;
      end else begin
         if (state == IDLE && (take_ls || take_if)) begin
            gnt_ls         <= take_ls;
            ram_rw_wen_o   <= take_ls && ls_wen_i;
            ram_rw_addr_o  <= take_ls ? ls_addr_i : if_addr_i;
            ram_rw_wdata_o <= take_ls ? ls_wdata_i : '0;
            ram_rw_wmask_o <= take_ls ? ls_wmask_i : '0;
            ram_rw_size_o  <= take_ls ? ls_size_i : 3'b011;
            streak_cnt     <= (take_ls && if_valid_i) ? ((streak_cnt == SMAX) ? SMAX : streak_cnt + 1'b1) : '0;
         end
         if (state == ISSUE)
            wait_cnt <= '0;
         // last WAIT cycle leaves the response; stores and timeouts return zero data
         if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
            rdata_q  <= (ram_rw_ready_i && !ram_rw_wen_o) ? ram_rw_data_i : '0;
            err_q    <= !ram_rw_ready_i;
         end
      end
   end
   assign ram_rw_cen_o = state == ISSUE;
   assign if_ready_o   = state == RESP && !gnt_ls;
   assign ls_ready_o   = state == RESP && gnt_ls;
   assign if_rdata_o   = if_ready_o ? rdata_q : '0;
   assign ls_rdata_o   = ls_ready_o ? rdata_q : '0;
   assign if_err_o     = if_ready_o && err_q;
   assign ls_err_o     = ls_ready_o && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, latency, timeout and reset abort
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid_i, if_ready_o, if_err_o;
   logic [63:0] if_addr_i, if_rdata_o;
   logic        ls_valid_i, ls_wen_i, ls_ready_o, ls_err_o;
   logic [63:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
   logic [7:0]  ls_wmask_i;
   logic [2:0]  ls_size_i;
   logic        ram_rw_cen_o, ram_rw_wen_o, ram_rw_ready_i;
   logic [63:0] ram_rw_addr_o, ram_rw_wdata_o, ram_rw_data_i;
   logic [7:0]  ram_rw_wmask_o;
   logic [2:0]  ram_rw_size_o;
   logic        cap_wen;
   logic [63:0] cap_wdata;
   logic [7:0]  cap_wmask;
   logic [2:0]  cap_size;
   int total = 0;
   int bad = 0;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid_i(if_valid_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
      .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
      .ls_valid_i(ls_valid_i), .ls_wen_i(ls_wen_i), .ls_addr_i(ls_addr_i),
      .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_size_i(ls_size_i),
      .ls_ready_o(ls_ready_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
      .ram_rw_cen_o(ram_rw_cen_o), .ram_rw_wen_o(ram_rw_wen_o), .ram_rw_addr_o(ram_rw_addr_o),
      .ram_rw_wdata_o(ram_rw_wdata_o), .ram_rw_wmask_o(ram_rw_wmask_o), .ram_rw_size_o(ram_rw_size_o),
      .ram_rw_ready_i(ram_rw_ready_i), .ram_rw_data_i(ram_rw_data_i)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_rdy"}, 64'({if_ready_o, ls_ready_o, if_err_o, ls_err_o, ram_rw_cen_o}), 64'd0);
      chk({tag, "_rd"}, if_rdata_o | ls_rdata_o, 64'd0);
   endtask

   // requests are already driven and the arbiter is in IDLE; lat<0 means memory never answers
   task automatic xfer(input string tag, input logic exp_ls, input logic [63:0] exp_addr, input int lat,
                       input logic [63:0] rd, input logic [63:0] exp_rd, input logic exp_err, input logic keep);
      int n;
      tick;
      chk({tag, "_cen"}, 64'(ram_rw_cen_o), 64'd1);
      chk({tag, "_addr"}, ram_rw_addr_o, exp_addr);
      cap_wen = ram_rw_wen_o;
      cap_wdata = ram_rw_wdata_o;
      cap_wmask = ram_rw_wmask_o;
      cap_size = ram_rw_size_o;
      ram_rw_data_i = rd;
      tick;
      chk({tag, "_cen1"}, 64'(ram_rw_cen_o), 64'd0);
      n = 0;
      while (n < 40 && !(if_ready_o || ls_ready_o)) begin
         ram_rw_ready_i = (n == lat);
         tick;
         n++;
      end
      ram_rw_ready_i = 1'b0;
      chk({tag, "_wait"}, 64'(n), 64'(lat < 0 ? 16 : lat + 1));
      chk({tag, "_lsrdy"}, 64'(ls_ready_o), 64'(exp_ls));
      chk({tag, "_ifrdy"}, 64'(if_ready_o), 64'(!exp_ls));
      chk({tag, "_data"}, exp_ls ? ls_rdata_o : if_rdata_o, exp_rd);
      chk({tag, "_err"}, 64'(exp_ls ? ls_err_o : if_err_o), 64'(exp_err));
      chk({tag, "_other"}, exp_ls ? {if_rdata_o[62:0], if_err_o} : {ls_rdata_o[62:0], ls_err_o}, 64'd0);
      if (!keep) begin
         if (exp_ls) ls_valid_i = 1'b0;
         else if_valid_i = 1'b0;
      end
      tick;
      chk_quiet({tag, "_idle"});
   endtask

   initial begin
      rst_n = 1'b0;
      {if_valid_i, ls_valid_i, ls_wen_i, ram_rw_ready_i} = '0;
      {if_addr_i, ls_addr_i, ls_wdata_i, ram_rw_data_i} = '0;
      ls_wmask_i = '0;
      ls_size_i = '0;
      tick;
      tick;
      chk_quiet("rst");
      chk("rst_addr", ram_rw_addr_o, 64'd0);
      chk("rst_fields", 64'({ram_rw_wen_o, ram_rw_wmask_o, ram_rw_size_o}), 64'd0);
      rst_n = 1'b1;

      if_valid_i = 1'b1;
      if_addr_i = 64'h8000_0000;
      xfer("if1", 1'b0, 64'h8000_0000, 0, 64'h0000_0013_0010_0093, 64'h0000_0013_0010_0093, 1'b0, 1'b0);
      chk("if1_fields", 64'({cap_wen, cap_wmask, cap_size}), 64'({1'b0, 8'h00, 3'b011}));

      ls_valid_i = 1'b1;
      ls_wen_i = 1'b1;
      ls_addr_i = 64'h8000_1008;
      ls_wdata_i = 64'hDEAD_BEEF;
      ls_wmask_i = 8'h0F;
      ls_size_i = 3'd2;
      xfer("st", 1'b1, 64'h8000_1008, 0, 64'h1234, 64'd0, 1'b0, 1'b0);
      chk("st_fields", 64'({cap_wen, cap_wmask, cap_size}), 64'({1'b1, 8'h0F, 3'd2}));
      chk("st_wdata", cap_wdata, 64'hDEAD_BEEF);
      ls_wen_i = 1'b0;
      ls_size_i = 3'd3;

      if_valid_i = 1'b1;
      if_addr_i = 64'h8000_0004;
      ls_valid_i = 1'b1;
      ls_addr_i = 64'h8000_2000;
      xfer("both_ls", 1'b1, 64'h8000_2000, 0, 64'hA, 64'hA, 1'b0, 1'b0);
      xfer("both_if", 1'b0, 64'h8000_0004, 0, 64'hB, 64'hB, 1'b0, 1'b0);

      if_valid_i = 1'b1;
      ls_valid_i = 1'b1;
      for (int i = 0; i < 4; i++)
         xfer($sformatf("strk_ls%0d", i), 1'b1, 64'h8000_2000, 1, 64'h100 + 64'(i), 64'h100 + 64'(i), 1'b0, 1'b1);
      xfer("strk_if", 1'b0, 64'h8000_0004, 0, 64'hC, 64'hC, 1'b0, 1'b0);
      xfer("strk_ls4", 1'b1, 64'h8000_2000, 0, 64'hD, 64'hD, 1'b0, 1'b0);

      ls_valid_i = 1'b1;
      ls_addr_i = 64'h8000_3000;
      xfer("tmo", 1'b1, 64'h8000_3000, -1, 64'hFFFF, 64'd0, 1'b1, 1'b0);
      ls_valid_i = 1'b1;
      xfer("post_tmo", 1'b1, 64'h8000_3000, 0, 64'h55, 64'h55, 1'b0, 1'b0);

      ls_valid_i = 1'b1;
      ls_addr_i = 64'h8000_4000;
      tick;
      chk("ab_cen", 64'(ram_rw_cen_o), 64'd1);
      tick;
      tick;
      rst_n = 1'b0;
      ls_valid_i = 1'b0;
      tick;
      rst_n = 1'b1;
      ram_rw_ready_i = 1'b1;
      ram_rw_data_i = 64'h77;
      chk_quiet("ab_rst");
      chk("ab_addr", ram_rw_addr_o, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_quiet($sformatf("ab_late%0d", i));
      end
      ram_rw_ready_i = 1'b0;
      if_valid_i = 1'b1;
      if_addr_i = 64'h8000_0010;
      xfer("post_rst", 1'b0, 64'h8000_0010, 0, 64'h99, 64'h99, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
